// File: rtl/counter_seq_checker_if.sv
// Counter-checker bus: sampled counter value in, lock/error status out.
// master drives the counter sample, slave is the checker.
interface counter_seq_checker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
);

  logic             q_valid;
  logic [WIDTH-1:0] q_in;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  modport master (
    output q_valid,
    output q_in,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  expected
  );

  modport slave (
    input  q_valid,
    input  q_in,
    output locked,
    output err_pulse,
    output err_count,
    output expected
  );

endinterface

// File: rtl/counter_seq_checker.sv
// Locks onto a +1 mod 2^WIDTH counter sequence and flags every break once locked,
// keeping a saturating count of breaks for pass/fail readout.
module counter_seq_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOCK_CYCLES = 3,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned ALLOW_HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  counter_seq_checker_if.slave  bus
);

  localparam int unsigned CNT_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOCK_CYCLES);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] hold_val;
  logic [WIDTH-1:0] resync_val;
  logic             is_match;
  logic             is_hold;

  // Sample classification against the current prediction
  assign hold_val   = expected_q - ONE;
  assign resync_val = bus.q_in + ONE;
  assign is_match   = (bus.q_in == expected_q);
  assign is_hold    = (ALLOW_HOLD != 0) && (bus.q_in == hold_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    // clear outranks a same-cycle sample
    if (clear) begin
      state_d     = IDLE;
      expected_d  = '0;
      match_cnt_d = '0;
      locked_d    = 1'b0;
      err_count_d = '0;
    end else if (bus.q_valid) begin
      unique case (state_q)
        IDLE: begin
          expected_d  = resync_val;
          match_cnt_d = '0;
          state_d     = ACQUIRE;
        end
        ACQUIRE: begin
          if (is_match) begin
            expected_d = expected_q + ONE;
            if (match_cnt_q >= CNT_LAST) begin
              match_cnt_d = CNT_FULL;
              locked_d    = 1'b1;
              state_d     = LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + CNT_ONE;
            end
          end else if (!is_hold) begin
            // Still acquiring: resync silently, no error is charged
            expected_d  = resync_val;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (is_match) begin
            expected_d = expected_q + ONE;
          end else if (!is_hold) begin
            err_pulse_d = 1'b1;
            err_count_d = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + ERR_ONE;
            locked_d    = 1'b0;
            expected_d  = resync_val;
            match_cnt_d = '0;
            state_d     = ACQUIRE;
          end
        end
        default: begin
          state_d     = IDLE;
          expected_d  = '0;
          match_cnt_d = '0;
          locked_d    = 1'b0;
        end
      endcase
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.expected  = expected_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed plus randomized check of counter_seq_checker against a behavioural model;
// dut0 uses defaults, dut1 uses ERR_W=2 with holds not tolerated.
module tb_counter_seq_checker;

  logic clk;
  logic rst_n;
  logic clear;

  counter_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus0 ();
  counter_seq_checker_if #(.WIDTH(4), .ERR_W(2)) bus1 ();

  counter_seq_checker #(.WIDTH(4), .LOCK_CYCLES(3), .ERR_W(8), .ALLOW_HOLD(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus0)
  );

  counter_seq_checker #(.WIDTH(4), .LOCK_CYCLES(3), .ERR_W(2), .ALLOW_HOLD(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural view: have we a reference value, are we locked, how many good steps
  typedef struct {
    bit act;
    bit lk;
    int exp;
    int run;
    int errs;
    bit pulse;
  } mdl_t;

  mdl_t m0, m1;
  int   n_tests;
  int   n_fail;

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.act = 0; z.lk = 0; z.exp = 0; z.run = 0; z.errs = 0; z.pulse = 0;
    return z;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit v, int s, bit c, int errmax, bit hold_ok);
    mdl_t n;
    bit   good;
    bit   stall;
    n = m;
    n.pulse = 0;
    if (c) return mdl_zero();
    if (!v) return n;
    if (!m.act) begin
      n.act = 1;
      n.exp = (s + 1) % 16;
      n.run = 0;
      return n;
    end
    good  = (s == m.exp);
    stall = hold_ok && (s == (m.exp + 15) % 16);
    if (good) begin
      n.exp = (m.exp + 1) % 16;
      if (!m.lk) begin
        n.run = m.run + 1;
        if (n.run >= 3) n.lk = 1;
      end
    end else if (!stall) begin
      if (m.lk) begin
        n.pulse = 1;
        n.errs  = (m.errs + 1 > errmax) ? errmax : m.errs + 1;
        n.lk    = 0;
      end
      n.exp = (s + 1) % 16;
      n.run = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " d0.locked"},    32'(bus0.locked),    32'(m0.lk));
    check({tag, " d0.err_pulse"}, 32'(bus0.err_pulse), 32'(m0.pulse));
    check({tag, " d0.err_count"}, 32'(bus0.err_count), 32'(m0.errs));
    check({tag, " d0.expected"},  32'(bus0.expected),  32'(m0.exp));
    check({tag, " d1.locked"},    32'(bus1.locked),    32'(m1.lk));
    check({tag, " d1.err_pulse"}, 32'(bus1.err_pulse), 32'(m1.pulse));
    check({tag, " d1.err_count"}, 32'(bus1.err_count), 32'(m1.errs));
    check({tag, " d1.expected"},  32'(bus1.expected),  32'(m1.exp));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare
  task automatic step(input string tag, input bit v, input int s, input bit c);
    bus0.q_valid = v;
    bus1.q_valid = v;
    bus0.q_in    = 4'(s);
    bus1.q_in    = 4'(s);
    clear        = c;
    @(posedge clk);
    m0 = mstep(m0, v, s, c, 255, 1'b1);
    m1 = mstep(m1, v, s, c, 3, 1'b0);
    #1;
    check_all(tag);
  endtask

  initial begin
    int cur;
    int pulses;
    int r;
    n_tests = 0;
    n_fail  = 0;
    m0 = mdl_zero();
    m1 = mdl_zero();
    rst_n = 1'b0;
    clear = 1'b0;
    bus0.q_valid = 1'b0;
    bus1.q_valid = 1'b0;
    bus0.q_in    = '0;
    bus1.q_in    = '0;

    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire from a clean count
    for (int i = 0; i <= 3; i++) step("t1", 1'b1, i, 1'b0);
    check("t1 locked_after_3", 32'(bus0.locked), 32'd1);
    step("t1", 1'b1, 4, 1'b0);
    check("t1 expected_5", 32'(bus0.expected), 32'd5);
    check("t1 err_count_0", 32'(bus0.err_count), 32'd0);

    // Wrap 15 -> 0 is a correct step
    for (int i = 5; i <= 17; i++) step("t2", 1'b1, i % 16, 1'b0);
    check("t2 locked_after_wrap", 32'(bus0.locked), 32'd1);
    check("t2 err_count_0", 32'(bus0.err_count), 32'd0);

    // Single glitch while locked
    for (int i = 2; i <= 5; i++) step("t3", 1'b1, i, 1'b0);
    check("t3 expected_6", 32'(bus0.expected), 32'd6);
    step("t3", 1'b1, 9, 1'b0);
    check("t3 err_pulse", 32'(bus0.err_pulse), 32'd1);
    check("t3 err_count_1", 32'(bus0.err_count), 32'd1);
    check("t3 unlocked", 32'(bus0.locked), 32'd0);
    check("t3 expected_10", 32'(bus0.expected), 32'd10);
    step("t3", 1'b1, 10, 1'b0);
    check("t3 pulse_one_cycle", 32'(bus0.err_pulse), 32'd0);
    step("t3", 1'b1, 11, 1'b0);
    step("t3", 1'b1, 12, 1'b0);
    check("t3 relocked", 32'(bus0.locked), 32'd1);

    // clear with a valid sample: clear wins
    step("t6c", 1'b1, 7, 1'b1);
    check("t6c expected_0", 32'(bus0.expected), 32'd0);
    check("t6c err_count_0", 32'(bus0.err_count), 32'd0);
    check("t6c unlocked", 32'(bus0.locked), 32'd0);

    // Counter leaving reset: stalls at 0 then counts
    for (int i = 0; i < 5; i++) step("t4", 1'b1, 0, 1'b0);
    for (int i = 1; i <= 3; i++) step("t4", 1'b1, i, 1'b0);
    check("t4 d0_locked", 32'(bus0.locked), 32'd1);
    check("t4 d0_no_err", 32'(bus0.err_count), 32'd0);
    check("t4 d1_locked", 32'(bus1.locked), 32'd1);
    check("t4 d1_no_err", 32'(bus1.err_count), 32'd0);

    // Five relock-then-break rounds: dut1 count saturates at 3
    cur = 3;
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      for (int k = 1; k <= 3; k++) begin
        step("t5", 1'b1, (cur + k) % 16, 1'b0);
        pulses += int'(bus1.err_pulse);
      end
      cur = (cur + 3) % 16;
      cur = (cur + 5) % 16;
      step("t5", 1'b1, cur, 1'b0);
      pulses += int'(bus1.err_pulse);
    end
    check("t5 pulses_5", 32'(pulses), 32'd5);
    check("t5 d1_saturated", 32'(bus1.err_count), 32'd3);
    check("t5 d0_count_5", 32'(bus0.err_count), 32'd5);

    // Async reset mid-lock: outputs drop with no clock edge
    for (int k = 1; k <= 3; k++) step("t6", 1'b1, (cur + k) % 16, 1'b0);
    check("t6 locked_before", 32'(bus0.locked), 32'd1);
    rst_n = 1'b0;
    #2;
    m0 = mdl_zero();
    m1 = mdl_zero();
    check_all("t6 async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 8; i <= 11; i++) step("t6 reacq", 1'b1, i, 1'b0);
    check("t6 relocked", 32'(bus0.locked), 32'd1);

    // Randomized counter with stalls, glitches, gaps and clears
    cur = 11;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(99));
      if (r < 20) begin
        step("rnd", 1'b0, int'($urandom_range(15)), 1'b0);
      end else if (r < 82) begin
        cur = (cur + 1) % 16;
        step("rnd", 1'b1, cur, 1'b0);
      end else if (r < 90) begin
        step("rnd", 1'b1, cur, 1'b0);
      end else if (r < 97) begin
        cur = int'($urandom_range(15));
        step("rnd", 1'b1, cur, 1'b0);
      end else begin
        step("rnd", 1'b1, cur, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
